// File: rtl/descramble_stream_pkg.sv
// Shared scrambler constants and keystream step.
// Used by both the receive descrambler and the transmit scrambler.
package descramble_stream_pkg;

  localparam int WORD_W = 5;
  localparam int TAP_HI = 4;
  localparam int TAP_LO = 2;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  function automatic logic [WORD_W-1:0] lfsr_next(
    input logic [WORD_W-1:0] s
  );
    return {s[WORD_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/descramble_stream_if.sv
// Valid/ready stream bundle for the descrambler.
// Scrambled words in, recovered words out.
interface descramble_stream_if;
  import descramble_stream_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] A;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] ip;

  modport master (
    output in_valid, A, out_ready,
    input  in_ready, out_valid, ip
  );

  modport slave (
    input  in_valid, A, out_ready,
    output in_ready, out_valid, ip
  );

endinterface

// File: rtl/descramble_stream_lfsr.sv
// Keystream register: loads a seed, advances once per word.
// With LFSR_EN=0 the seed is held as a fixed key.
module descramble_lfsr
  import descramble_stream_pkg::*;
#(
  parameter int LFSR_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WORD_W-1:0] seed_i,
  input  logic              adv_i,
  output logic [WORD_W-1:0] state_o
);

  logic [WORD_W-1:0] lfsr_q;
  logic [WORD_W-1:0] lfsr_d;

  // next keystream value: seed load beats advance
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (adv_i && (LFSR_EN != 0)) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // keystream state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/descramble_stream.sv
// Descrambler: XORs each accepted word with the keystream.
// One registered output stage, stable under backpressure.
module descramble_stream
  import descramble_stream_pkg::*;
#(
  parameter int LFSR_EN = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic [WORD_W-1:0] x,
  descramble_stream_if.slave s,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              key_err
);

  state_e            state_q;
  state_e            state_d;
  logic [WORD_W-1:0] ip_q;
  logic [WORD_W-1:0] ip_d;
  logic              ov_q;
  logic              ov_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              err_q;
  logic              err_d;
  logic [WORD_W-1:0] key;
  logic              seed_ok;
  logic              run;
  logic              rdy;
  logic              acc;

  // a zero seed would lock the LFSR, so it is refused
  assign seed_ok = key_load &
                   ((x != '0) || (LFSR_EN == 0));
  assign run = (state_q == RUN);
  assign rdy = run & ~key_load &
               (~ov_q | s.out_ready);
  assign acc = s.in_valid & rdy;

  descramble_lfsr #(
    .LFSR_EN(LFSR_EN)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (seed_ok),
    .seed_i (x),
    .adv_i  (acc),
    .state_o(key)
  );

  // FSM next state and output-stage next values
  always_comb begin
    state_d = state_q;
    ip_d    = ip_q;
    ov_d    = ov_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seed_ok) state_d = RUN;
        err_d = s.in_valid;
      end
      RUN: state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (key_load && !seed_ok) err_d = 1'b1;
    if (acc) begin
      ip_d  = s.A ^ key;
      ov_d  = 1'b1;
      cnt_d = cnt_q + CNT_W'(1);
    end else if (s.out_ready) begin
      ov_d = 1'b0;
    end
    if (seed_ok) cnt_d = '0;
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ip_q    <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign s.in_ready  = rdy;
  assign s.out_valid = ov_q;
  assign s.ip        = ip_q;
  assign word_cnt    = cnt_q;
  assign key_err     = err_q;

endmodule
